// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB one phase per clock,
// driving datapath strobes, memory handshakes, data-access timeout and a retired-instruction count.
module multicycle_seq_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       ins_op,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             rg_wr,
  output logic             dataMem_wr,
  output logic             dataMem_rd,
  output logic [2:0]       alu_op,
  output logic             RegOut,
  output logic [1:0]       M2Reg,
  output logic             immCalc,
  output logic             illegal,
  output logic             bus_err,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t             state_q, state_d;
  logic [WCW-1:0]     wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic op_nop, op_st, op_ld, op_legal, op_regout;

  always_comb begin
    op_nop    = (ins_op == 7'd0);
    op_st     = (ins_op == 7'd2);
    op_ld     = (ins_op == 7'd5);
    op_legal  = (ins_op <= 7'd5);
    op_regout = (ins_op == 7'd3) || (ins_op == 7'd4) || (ins_op == 7'd5);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    imem_req   = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    rg_wr      = 1'b0;
    dataMem_wr = 1'b0;
    dataMem_rd = 1'b0;
    alu_op     = '0;
    RegOut     = 1'b0;
    M2Reg      = 2'b00;
    immCalc    = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    busy       = (state_q != S_FETCH);

    // Operand/writeback selects stay stable from EXEC until the instruction ends.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      RegOut  = op_regout;
      immCalc = (ins_op == 7'd4);
      M2Reg   = op_st ? 2'b10 : (op_ld ? 2'b01 : 2'b00);
    end

    case (state_q)
      S_FETCH: begin
        imem_req = run;
        if (run && imem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_nop) begin
          state_d = S_FETCH;
          cnt_d   = cnt_q + 1'b1;
        end else if (!op_legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d  = '0;
        state_d = (op_st || op_ld) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dataMem_wr = op_st;
        dataMem_rd = op_ld;
        // An ack on the final allowed wait cycle wins over the timeout.
        if (dmem_ack) begin
          if (op_ld) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rg_wr   = 1'b1;
        state_d = S_FETCH;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Strobes are combinational, so hold them low for the whole reset window.
    if (!rst_n) begin
      imem_req   = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      rg_wr      = 1'b0;
      dataMem_wr = 1'b0;
      dataMem_rd = 1'b0;
      RegOut     = 1'b0;
      M2Reg      = 2'b00;
      immCalc    = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      busy       = 1'b0;
    end
  end

  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Self-checking bench for multicycle_seq_ctrl: vector table, randomized per-instruction
// schedules checked cycle by cycle, counter wrap and reset corner cases.
module tb_multicycle_seq_ctrl;

  localparam int MT = 8;
  localparam int P_STALL = 0, P_ACCEPT = 1, P_DEC = 2, P_EXEC = 3,
                 P_MWAIT = 4, P_MACK = 5, P_MTO = 6, P_WB = 7;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, dmem_ack;
  logic [6:0]  ins_op;

  logic        imem_req, ir_wr, pc_wr, rg_wr, dataMem_wr, dataMem_rd;
  logic [2:0]  alu_op;
  logic        RegOut, immCalc, illegal, bus_err, busy;
  logic [1:0]  M2Reg;
  logic [15:0] instr_cnt;

  logic        imem_req4, ir_wr4, pc_wr4, rg_wr4, wr4, rd4;
  logic [2:0]  alu_op4;
  logic        reg_out4, imm4, ill4, berr4, busy4;
  logic [1:0]  m2_4;
  logic [3:0]  instr_cnt4;

  multicycle_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ins_op(ins_op), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .rg_wr(rg_wr), .dataMem_wr(dataMem_wr), .dataMem_rd(dataMem_rd), .alu_op(alu_op),
    .RegOut(RegOut), .M2Reg(M2Reg), .immCalc(immCalc), .illegal(illegal),
    .bus_err(bus_err), .busy(busy), .instr_cnt(instr_cnt)
  );

  multicycle_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .ins_op(ins_op), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .imem_req(imem_req4), .ir_wr(ir_wr4), .pc_wr(pc_wr4),
    .rg_wr(rg_wr4), .dataMem_wr(wr4), .dataMem_rd(rd4), .alu_op(alu_op4),
    .RegOut(reg_out4), .M2Reg(m2_4), .immCalc(imm4), .illegal(ill4),
    .bus_err(berr4), .busy(busy4), .instr_cnt(instr_cnt4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    bit imem_req, ir_wr, pc_wr, rg_wr, wr, rd;
    int alu_op;
    bit reg_out;
    int m2;
    bit imm, ill, berr, busy;
  } exp_t;

  typedef struct {
    int op, mdelay;
    int cyc, wr, rd, rg, ill, berr, m2, inc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_exp(input exp_t e);
    return {e.imem_req, e.ir_wr, e.pc_wr, e.rg_wr, e.wr, e.rd, 3'(e.alu_op),
            e.reg_out, 2'(e.m2), e.imm, e.ill, e.berr, e.busy};
  endfunction

  // Expected strobes for one cycle of an instruction, from its phase and opcode.
  function automatic exp_t phase_exp(input int ph, input int op, input bit r);
    exp_t e;
    bit fetch, mem;
    e = '{default: 0};
    fetch      = (ph == P_STALL) || (ph == P_ACCEPT);
    mem        = (ph == P_MWAIT) || (ph == P_MACK) || (ph == P_MTO);
    e.busy     = !fetch;
    e.imem_req = fetch && r;
    e.ir_wr    = (ph == P_ACCEPT);
    e.pc_wr    = (ph == P_ACCEPT);
    e.ill      = (ph == P_DEC) && (op > 5);
    e.berr     = (ph == P_MTO);
    e.rg_wr    = (ph == P_WB);
    e.wr       = mem && (op == 2);
    e.rd       = mem && (op == 5);
    if (ph >= P_EXEC) begin
      e.reg_out = (op == 3) || (op == 4) || (op == 5);
      e.imm     = (op == 4);
      e.m2      = (op == 2) ? 2 : ((op == 5) ? 1 : 0);
    end
    return e;
  endfunction

  task automatic check_outs(input exp_t e, input string tag);
    chk({tag, ".imem_req"}, int'(imem_req), int'(e.imem_req));
    chk({tag, ".ir_wr"}, int'(ir_wr), int'(e.ir_wr));
    chk({tag, ".pc_wr"}, int'(pc_wr), int'(e.pc_wr));
    chk({tag, ".rg_wr"}, int'(rg_wr), int'(e.rg_wr));
    chk({tag, ".dmem_wr"}, int'(dataMem_wr), int'(e.wr));
    chk({tag, ".dmem_rd"}, int'(dataMem_rd), int'(e.rd));
    chk({tag, ".alu_op"}, int'(alu_op), e.alu_op);
    chk({tag, ".RegOut"}, int'(RegOut), int'(e.reg_out));
    chk({tag, ".M2Reg"}, int'(M2Reg), e.m2);
    chk({tag, ".immCalc"}, int'(immCalc), int'(e.imm));
    chk({tag, ".illegal"}, int'(illegal), int'(e.ill));
    chk({tag, ".bus_err"}, int'(bus_err), int'(e.berr));
    chk({tag, ".busy"}, int'(busy), int'(e.busy));
    chk({tag, ".cnt"}, int'(instr_cnt), exp_cnt % 65536);
    chk({tag, ".dut4_outs"},
        int'({imem_req4, ir_wr4, pc_wr4, rg_wr4, wr4, rd4, alu_op4, reg_out4, m2_4,
              imm4, ill4, berr4, busy4}), int'(pack_exp(e)));
    chk({tag, ".cnt4"}, int'(instr_cnt4), exp_cnt % 16);
  endtask

  task automatic do_cycle(input exp_t e, input string tag, input bit retire);
    @(negedge clk);
    check_outs(e, tag);
    if (retire) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Builds the phase list an instruction must walk through, then drives and checks it.
  task automatic run_sched(input int op, input int fstall, input int mdelay);
    int q[$];
    bit ret;
    for (int i = 0; i < fstall; i++) q.push_back(P_STALL);
    q.push_back(P_ACCEPT);
    q.push_back(P_DEC);
    if (op >= 1 && op <= 5) begin
      q.push_back(P_EXEC);
      if (op == 2 || op == 5) begin
        if (mdelay < MT) begin
          for (int i = 0; i < mdelay; i++) q.push_back(P_MWAIT);
          q.push_back(P_MACK);
          if (op == 5) q.push_back(P_WB);
        end else begin
          for (int i = 0; i < MT - 1; i++) q.push_back(P_MWAIT);
          q.push_back(P_MTO);
        end
      end else begin
        q.push_back(P_WB);
      end
    end
    foreach (q[i]) begin
      int ph;
      ph = q[i];
      if (ph == P_STALL) begin
        if ($urandom_range(1, 0) == 1) begin
          run = 1'b1; imem_ack = 1'b0;
        end else begin
          run = 1'b0; imem_ack = 1'($urandom_range(1, 0));
        end
        ins_op   = 7'($urandom_range(127, 0));
        dmem_ack = 1'($urandom_range(1, 0));
      end else if (ph == P_ACCEPT) begin
        run = 1'b1; imem_ack = 1'b1;
        ins_op   = 7'($urandom_range(127, 0));
        dmem_ack = 1'($urandom_range(1, 0));
      end else begin
        run      = 1'($urandom_range(1, 0));
        imem_ack = 1'($urandom_range(1, 0));
        ins_op   = 7'(op);
        if (ph == P_MACK) dmem_ack = 1'b1;
        else if (ph == P_MWAIT || ph == P_MTO) dmem_ack = 1'b0;
        else dmem_ack = 1'($urandom_range(1, 0));
      end
      ret = (ph == P_DEC && op == 0) || (ph == P_MACK && op == 2) || (ph == P_WB);
      do_cycle(phase_exp(ph, op, run), "rand", ret);
    end
  endtask

  // Runs one instruction with immediate fetch and dmem_ack after mdelay MEM cycles, tallying strobes.
  task automatic exec_tally(input int op, input int mdelay, output int cyc, output int wr,
                            output int rd, output int rg, output int ill, output int berr,
                            output int m2);
    int mem_seen;
    bit done;
    cyc = 0; wr = 0; rd = 0; rg = 0; ill = 0; berr = 0; m2 = 0;
    mem_seen = 0; done = 1'b0;
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0; ins_op = 7'(op);
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        run = 1'b0; imem_ack = 1'b0;
        dmem_ack = (mem_seen == mdelay);
      end
      @(negedge clk);
      if (n > 0 && !busy) begin
        done = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      cyc++;
      wr   += int'(dataMem_wr);
      rd   += int'(dataMem_rd);
      rg   += int'(rg_wr);
      ill  += int'(illegal);
      berr += int'(bus_err);
      m2   |= int'(M2Reg);
      if (dataMem_wr || dataMem_rd) mem_seen++;
      @(posedge clk);
      #1;
    end
    if (!done) chk("tally.timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    exp_t idle;
    int cyc, wr, rd, rg, ill, berr, m2;

    tbl[0]  = '{1, 0, 4, 0, 0, 1, 0, 0, 0, 1};
    tbl[1]  = '{2, 2, 6, 3, 0, 0, 0, 0, 2, 1};
    tbl[2]  = '{5, 99, 11, 0, 8, 0, 0, 1, 1, 0};
    tbl[3]  = '{64, 0, 2, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{3, 0, 4, 0, 0, 1, 0, 0, 0, 1};
    tbl[6]  = '{4, 0, 4, 0, 0, 1, 0, 0, 0, 1};
    tbl[7]  = '{5, 0, 5, 0, 1, 1, 0, 0, 1, 1};
    tbl[8]  = '{5, 7, 12, 0, 8, 1, 0, 0, 1, 1};
    tbl[9]  = '{2, 0, 4, 1, 0, 0, 0, 0, 2, 1};
    tbl[10] = '{6, 0, 2, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{127, 0, 2, 0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{2, 8, 11, 8, 0, 0, 0, 1, 2, 0};
    idle = phase_exp(P_STALL, 0, 1'b0);

    // Reset with every input asserted: all outputs must be 0.
    rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; ins_op = 7'd5;
    #2;
    check_outs(idle, "reset");
    @(posedge clk);
    #1;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b1;
    do_cycle(idle, "idle", 1'b0);
    do_cycle(idle, "idle", 1'b0);

    foreach (tbl[i]) begin
      exec_tally(tbl[i].op, tbl[i].mdelay, cyc, wr, rd, rg, ill, berr, m2);
      chk($sformatf("tbl%0d.cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d.wr", i), wr, tbl[i].wr);
      chk($sformatf("tbl%0d.rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d.rg_wr", i), rg, tbl[i].rg);
      chk($sformatf("tbl%0d.illegal", i), ill, tbl[i].ill);
      chk($sformatf("tbl%0d.bus_err", i), berr, tbl[i].berr);
      chk($sformatf("tbl%0d.M2Reg", i), m2, tbl[i].m2);
      exp_cnt += tbl[i].inc;
      chk($sformatf("tbl%0d.cnt", i), int'(instr_cnt), exp_cnt % 65536);
    end

    for (int n = 0; n < 150; n++) begin
      int op;
      op = ($urandom_range(3, 0) == 0) ? int'($urandom_range(127, 6)) : int'($urandom_range(5, 0));
      run_sched(op, int'($urandom_range(2, 0)), int'($urandom_range(9, 0)));
    end

    // Fresh reset, then 16 addi: the 4-bit counter must wrap to 0.
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    exp_cnt = 0;
    check_outs(idle, "rst2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      exec_tally(4, 0, cyc, wr, rd, rg, ill, berr, m2);
      chk("wrap.cycles", cyc, 4);
      chk("wrap.rg_wr", rg, 1);
      exp_cnt++;
      chk("wrap.cnt4", int'(instr_cnt4), exp_cnt % 16);
      chk("wrap.cnt16", int'(instr_cnt), exp_cnt);
    end

    // Reset asserted in the MEM phase of a load: no writeback may follow.
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0; ins_op = 7'd5;
    do_cycle(phase_exp(P_ACCEPT, 5, 1'b1), "mid.fetch", 1'b0);
    run = 1'b0; imem_ack = 1'b0;
    do_cycle(phase_exp(P_DEC, 5, 1'b0), "mid.dec", 1'b0);
    do_cycle(phase_exp(P_EXEC, 5, 1'b0), "mid.exec", 1'b0);
    do_cycle(phase_exp(P_MWAIT, 5, 1'b0), "mid.mem", 1'b0);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check_outs(idle, "mid.rst");
    @(negedge clk);
    check_outs(idle, "mid.rst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1; dmem_ack = 1'b1;
    for (int n = 0; n < 3; n++) do_cycle(idle, "mid.after", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
